// File: rtl/hit_write_arbiter_pkg.sv
// Shared widths and state encoding for the hit-memory write-port arbiter.
package hit_write_arbiter_pkg;

    localparam int SSIDBITS     = 8;
    localparam int NCOLS_HLM    = 16;
    localparam int NREQ_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/hit_write_arbiter_pick.sv
// Combinational round-robin pick: first set request searching cyclically from pointer+1.
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] pointer,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    always_comb begin
        logic w_found;
        int   w_j;
        w_found = 1'b0;
        w_j     = 0;
        grant   = '0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            w_j = (int'(pointer) + k) % N;
            if (!w_found && req[w_j]) begin
                w_found    = 1'b1;
                grant[w_j] = 1'b1;
                idx        = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/hit_write_arbiter.sv
// Shares the single hit-memory write port between NREQ sources with round-robin grants.
// Handshake: a source word transfers on a rising clock edge where req_valid[i] && req_ready[i].
module hit_write_arbiter
    import hit_write_arbiter_pkg::*;
#(
    parameter int SSIDBITS_P  = SSIDBITS,
    parameter int NCOLS_HLM_P = NCOLS_HLM,
    parameter int NREQ        = NREQ_DEFAULT,
    parameter int CNTBITS     = 16,
    localparam int IDW        = $clog2(NREQ)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*SSIDBITS_P-1:0]    req_SSID,
    input  logic [NREQ*NCOLS_HLM_P-1:0]   req_hitInfo,
    input  logic [NREQ-1:0]               req_done,
    input  logic                          mem_busy,
    output logic [SSIDBITS_P-1:0]         SSID,
    output logic [NCOLS_HLM_P-1:0]        hitInfo,
    output logic                          newAddress,
    output logic [IDW-1:0]                grant_id,
    output logic [CNTBITS-1:0]            issue_count,
    output logic                          all_done,
    output logic [1:0]                    dbg_state
);

    arb_state_t               r_state;
    arb_state_t               w_state_nxt;
    logic [IDW-1:0]           r_ptr;
    logic [SSIDBITS_P-1:0]    r_ssid;
    logic [NCOLS_HLM_P-1:0]   r_hitinfo;
    logic                     r_new_addr;
    logic [IDW-1:0]           r_grant_id;
    logic [CNTBITS-1:0]       r_count;
    logic                     r_all_done;

    logic [NREQ-1:0]          w_pick_grant;
    logic [IDW-1:0]           w_pick_idx;
    logic                     w_ready_en;
    logic                     w_xfer;
    logic                     w_complete;
    logic [SSIDBITS_P-1:0]    w_sel_ssid;
    logic [NCOLS_HLM_P-1:0]   w_sel_hitinfo;

    // Pick depends only on valids and pointer, never on the data buses.
    rr_priority_pick #(.N(NREQ), .IW(IDW)) u_pick (
        .req     (req_valid),
        .pointer (r_ptr),
        .grant   (w_pick_grant),
        .idx     (w_pick_idx)
    );

    assign w_ready_en = !mem_busy && (r_state != ST_DONE) && (r_state != ST_HOLD);
    assign req_ready  = w_ready_en ? w_pick_grant : '0;
    assign w_xfer     = |(req_valid & req_ready);
    assign w_complete = (&req_done) && !(|req_valid) && !w_xfer;

    always_comb begin
        w_sel_ssid    = req_SSID[w_pick_idx*SSIDBITS_P +: SSIDBITS_P];
        w_sel_hitinfo = req_hitInfo[w_pick_idx*NCOLS_HLM_P +: NCOLS_HLM_P];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_complete)
                    w_state_nxt = ST_DONE;
                else if (|req_valid)
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_complete)
                    w_state_nxt = ST_DONE;
                else if (mem_busy)
                    w_state_nxt = ST_HOLD;
                else if (!(|req_valid))
                    w_state_nxt = ST_IDLE;
            end
            ST_HOLD: begin
                if (!mem_busy)
                    w_state_nxt = ST_RUN;
            end
            ST_DONE: w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= IDW'(NREQ - 1);
            r_ssid     <= '1;
            r_hitinfo  <= '1;
            r_new_addr <= 1'b0;
            r_grant_id <= '0;
            r_count    <= '0;
            r_all_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_new_addr <= w_xfer;
            if (w_xfer) begin
                r_ssid     <= w_sel_ssid;
                r_hitinfo  <= w_sel_hitinfo;
                r_grant_id <= w_pick_idx;
                r_ptr      <= w_pick_idx;
                if (r_count != {CNTBITS{1'b1}})
                    r_count <= r_count + 1'b1;
            end
            if (w_state_nxt == ST_DONE)
                r_all_done <= 1'b1;
        end
    end

    assign SSID        = r_ssid;
    assign hitInfo     = r_hitinfo;
    assign newAddress  = r_new_addr;
    assign grant_id    = r_grant_id;
    assign issue_count = r_count;
    assign all_done    = r_all_done;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_hit_write_arbiter.sv
// Directed bench for hit_write_arbiter: reset, single word, round robin, back-pressure, completion, saturation.
module tb_hit_write_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_done;
    logic [31:0] req_SSID;
    logic [63:0] req_hitInfo;
    logic        mem_busy;

    logic [3:0]  req_ready;
    logic [7:0]  SSID;
    logic [15:0] hitInfo;
    logic        newAddress;
    logic [1:0]  grant_id;
    logic [15:0] issue_count;
    logic        all_done;
    logic [1:0]  dbg_state;

    logic [3:0]  s_req_ready;
    logic [7:0]  s_SSID;
    logic [15:0] s_hitInfo;
    logic        s_newAddress;
    logic [1:0]  s_grant_id;
    logic [3:0]  s_issue_count;
    logic        s_all_done;
    logic [1:0]  s_dbg_state;

    int checks   = 0;
    int failures = 0;

    hit_write_arbiter #(.NREQ(4), .CNTBITS(16)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_SSID(req_SSID), .req_hitInfo(req_hitInfo), .req_done(req_done),
        .mem_busy(mem_busy), .SSID(SSID), .hitInfo(hitInfo), .newAddress(newAddress),
        .grant_id(grant_id), .issue_count(issue_count), .all_done(all_done),
        .dbg_state(dbg_state)
    );

    hit_write_arbiter #(.NREQ(4), .CNTBITS(4)) dut_sat (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_SSID(req_SSID), .req_hitInfo(req_hitInfo), .req_done(req_done),
        .mem_busy(mem_busy), .SSID(s_SSID), .hitInfo(s_hitInfo), .newAddress(s_newAddress),
        .grant_id(s_grant_id), .issue_count(s_issue_count), .all_done(s_all_done),
        .dbg_state(s_dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic set_word(input int src, input logic [7:0] ssid);
        req_SSID[src*8 +: 8]     = ssid;
        req_hitInfo[src*16 +: 16] = {8'h00, ssid};
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        req_valid   = '0;
        req_done    = '0;
        req_SSID    = '0;
        req_hitInfo = '0;
        mem_busy    = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (SSID !== 8'hFF) begin failures++; $display("FAIL reset_ssid got=%h exp=ff", SSID); end
        checks++; if (hitInfo !== 16'hFFFF) begin failures++; $display("FAIL reset_hitinfo got=%h exp=ffff", hitInfo); end
        checks++; if (newAddress !== 1'b0) begin failures++; $display("FAIL reset_newaddr got=%b exp=0", newAddress); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
        checks++; if (issue_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", issue_count); end
        checks++; if (all_done !== 1'b0) begin failures++; $display("FAIL reset_all_done got=%b exp=0", all_done); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clock);
        set_word(2, 8'h37);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
        @(posedge clock); #1;
        req_valid = '0;
        checks++; if (newAddress !== 1'b1) begin failures++; $display("FAIL single_newaddr got=%b exp=1", newAddress); end
        checks++; if (SSID !== 8'h37) begin failures++; $display("FAIL single_ssid got=%h exp=37", SSID); end
        checks++; if (hitInfo !== 16'h0037) begin failures++; $display("FAIL single_hitinfo got=%h exp=0037", hitInfo); end
        checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL single_grant_id got=%0d exp=2", grant_id); end
        checks++; if (issue_count !== 16'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", issue_count); end
        @(posedge clock); #1;
        checks++; if (newAddress !== 1'b0) begin failures++; $display("FAIL single_strobe_len got=%b exp=0", newAddress); end
        checks++; if (SSID !== 8'h37) begin failures++; $display("FAIL single_hold_ssid got=%h exp=37", SSID); end
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++; if (SSID !== 8'hFF) begin failures++; $display("FAIL areset_ssid got=%h exp=ff", SSID); end
        checks++; if (hitInfo !== 16'hFFFF) begin failures++; $display("FAIL areset_hitinfo got=%h exp=ffff", hitInfo); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL areset_grant_id got=%0d exp=0", grant_id); end
        checks++; if (issue_count !== 16'd0) begin failures++; $display("FAIL areset_count got=%0d exp=0", issue_count); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) set_word(i, 8'h10 + 8'(i));
        @(negedge clock);
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock); #1;
            checks++; if (newAddress !== 1'b1) begin failures++; $display("FAIL rr_newaddr c=%0d got=%b exp=1", c, newAddress); end
            checks++; if (grant_id !== 2'(c % 4)) begin failures++; $display("FAIL rr_order c=%0d got=%0d exp=%0d", c, grant_id, c % 4); end
            checks++; if (SSID !== 8'h10 + 8'(c % 4)) begin failures++; $display("FAIL rr_ssid c=%0d got=%h exp=%h", c, SSID, 8'h10 + 8'(c % 4)); end
        end
        @(negedge clock);
        req_valid = '0;
        checks++; if (issue_count !== 16'd8) begin failures++; $display("FAIL rr_count got=%0d exp=8", issue_count); end
    endtask

    task automatic test_back_pressure();
        int seen;
        seen = 0;
        do_reset();
        for (int i = 0; i < 4; i++) set_word(i, 8'h20 + 8'(i));
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            req_valid = 4'hF;
            mem_busy  = (c >= 3 && c <= 5);
            #1;
            if (mem_busy) begin
                checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready c=%0d got=%b exp=0000", c, req_ready); end
            end
            @(posedge clock); #1;
            if (newAddress) begin
                checks++; if (grant_id !== 2'(seen % 4)) begin failures++; $display("FAIL bp_order n=%0d got=%0d exp=%0d", seen, grant_id, seen % 4); end
                checks++; if (SSID !== 8'h20 + 8'(seen % 4)) begin failures++; $display("FAIL bp_ssid n=%0d got=%h exp=%h", seen, SSID, 8'h20 + 8'(seen % 4)); end
                seen++;
            end
        end
        @(negedge clock);
        req_valid = '0;
        mem_busy  = 1'b0;
        checks++; if (issue_count !== 16'(seen)) begin failures++; $display("FAIL bp_lost got=%0d exp=%0d", issue_count, seen); end
        checks++; if (seen < 7) begin failures++; $display("FAIL bp_progress got=%0d exp=>=7", seen); end
    endtask

    task automatic test_completion();
        do_reset();
        for (int w = 0; w < 23; w++) begin
            @(negedge clock);
            set_word(0, 8'(w));
            req_valid = 4'b0001;
            req_done  = (w == 22) ? 4'hF : 4'h0;
        end
        @(negedge clock);
        req_valid = '0;
        #1;
        checks++; if (newAddress !== 1'b1 || SSID !== 8'h16) begin failures++; $display("FAIL done_last_word got=%b/%h exp=1/16", newAddress, SSID); end
        checks++; if (all_done !== 1'b0) begin failures++; $display("FAIL done_early got=%b exp=0", all_done); end
        @(posedge clock); #1;
        checks++; if (all_done !== 1'b1) begin failures++; $display("FAIL done_rise got=%b exp=1", all_done); end
        checks++; if (issue_count !== 16'd23) begin failures++; $display("FAIL done_count got=%0d exp=23", issue_count); end
        checks++; if (dbg_state !== 2'd3) begin failures++; $display("FAIL done_state got=%0d exp=3", dbg_state); end
        @(negedge clock);
        set_word(0, 8'h99);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL done_late_ready got=%b exp=0000", req_ready); end
        @(posedge clock); #1;
        checks++; if (newAddress !== 1'b0 || issue_count !== 16'd23 || all_done !== 1'b1) begin
            failures++; $display("FAIL done_late_ignored got=%b/%0d/%b exp=0/23/1", newAddress, issue_count, all_done);
        end
        @(negedge clock);
        req_valid = '0;
    endtask

    task automatic test_saturation_reset();
        do_reset();
        @(negedge clock);
        set_word(1, 8'h55);
        req_valid = 4'b0010;
        repeat (20) @(posedge clock);
        @(negedge clock);
        req_valid = '0;
        checks++; if (s_issue_count !== 4'd15) begin failures++; $display("FAIL sat_count got=%0d exp=15", s_issue_count); end
        checks++; if (issue_count !== 16'd20) begin failures++; $display("FAIL sat_wide_count got=%0d exp=20", issue_count); end
        @(negedge clock);
        set_word(0, 8'hAA);
        req_valid = 4'b0001;
        #2 reset = 1'b1;
        #1;
        checks++; if (newAddress !== 1'b0) begin failures++; $display("FAIL rst_pending_now got=%b exp=0", newAddress); end
        @(posedge clock); #1;
        checks++; if (newAddress !== 1'b0) begin failures++; $display("FAIL rst_pending_edge got=%b exp=0", newAddress); end
        @(negedge clock);
        req_valid = '0;
        reset     = 1'b0;
        @(posedge clock); #1;
        checks++; if (newAddress !== 1'b0 || issue_count !== 16'd0 || SSID !== 8'hFF) begin
            failures++; $display("FAIL rst_pending_after got=%b/%0d/%h exp=0/0/ff", newAddress, issue_count, SSID);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_async_reset();
        test_round_robin();
        test_back_pressure();
        test_completion();
        test_saturation_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
